shift_seq: RTL
==============

Name: shift_seq

Overview:
Sequencer for the 4-bit serial-in/parallel-out shift register. It accepts a parallel word on a start/busy handshake and drives it onto the register's serial input, MSB first, one bit per clock. It then reads the register's parallel output back, captures it, and flags any mismatch. It sits between a parallel producer and the shift register, which shares its clock and reset.

Parameters:
WIDTH, 4, word width; equals the shift register length.
GAP, 1, idle cycles (si=0) inserted after each word before a new start is accepted; 0 is legal.

Ports:
ck     input   1      clock; all state updates on the rising edge
res    input   1      reset, synchronous, active-high
start  input   1      request to send din; accepted only when busy=0
din    input   WIDTH  word to serialize; sampled on the accepting edge only
si     output  1      serial bit to the shift register's si input
sen    output  1      high while si carries a valid data bit
q_in   input   WIDTH  parallel q of the shift register
busy   output  1      high whenever state is not IDLE
done   output  1      one-cycle pulse: word captured
word   output  WIDTH  last captured q_in; holds until the next capture
err    output  1      sticky: some capture differed from the sent word

Behaviour:
- Reset (res=1 at an edge) wins over everything.
  - State becomes IDLE.
  - si=0, sen=0, busy=0, done=0, word=0, err=0; the shift latch and counters clear.
  - Reset mid-word aborts the word with no done pulse.
- The state is held in registers. si, sen and busy decode from registered state only, so they are glitch-free and stable for the whole cycle.
- FSM states: IDLE, SHIFT, CHECK, GAP.
  - IDLE:
    - si=0, sen=0, busy=0.
    - On an edge with start=1, latch din into the shift latch sh and into exp, clear bit counter cnt, go to SHIFT.
  - SHIFT:
    - si=sh[WIDTH-1], sen=1, busy=1.
    - Each edge: sh shifts left with 0 fill, cnt increments.
    - On the edge with cnt==WIDTH-1, go to CHECK.
    - Exactly WIDTH cycles in SHIFT.
  - CHECK:
    - si=0, sen=0, busy=1. The downstream register has sampled its last bit, so q_in should equal exp.
    - At the edge: word<=q_in, done<=1, err<=err|(q_in!=exp).
    - Go to GAP if GAP>0, else IDLE.
  - GAP:
    - si=0, sen=0, busy=1.
    - Counts GAP cycles, then goes to IDLE.
- done is registered. It is high for exactly the one cycle after the CHECK edge and low otherwise.
- Timing, with start accepted at edge E0:
  - MSB drives si in the cycle E0..E1, LSB in the cycle E(W-1)..EW.
  - CHECK occupies EW..E(W+1).
  - done and the new word are visible from E(W+1).
  - busy falls at E(W+1+GAP).
  - The earliest next acceptance is edge E(W+2+GAP).
- start while busy=1 is ignored, not queued. din is don't-care except on the accepting edge.
- start and res in the same cycle: reset wins and the word is not accepted.
- err clears only on reset. Multiple mismatches keep err=1.
- word width rule: a straight WIDTH-bit copy; no arithmetic.
- The downstream register shifts every clock. In IDLE/GAP, si=0 flushes zeros into it, which is harmless because q_in is sampled only in CHECK.

Test Plan:
1. Reset: hold res=1 for 2 cycles with start=1 -> busy=0, si=0, done=0, word=0000, err=0; nothing accepted.
2. Single word: din=1011, start pulse at E0 -> si sequence 1,0,1,1 on cycles E0..E4 with sen=1; done=1 exactly one cycle from E5; word=1011; err=0; busy low from E6 (GAP=1).
3. Back-to-back: start held high, din=0110 then 1001 -> second acceptance at E7, not earlier; starts during busy ignored; words 0110 then 1001 captured; done pulses at E5 and E12.
4. Mismatch: bench forces q_in=0000 during CHECK for din=1111 -> word=0000, err=1. A following correct word 0101 -> word=0101 and err stays 1 until res.
5. Reset mid-operation: res=1 at E2 of word 1100 -> IDLE next cycle, si=0, no done pulse; a new start for 0011 afterwards completes with word=0011, err=0.
6. GAP=0 build: din=1000 -> done from E5, busy low from E5, next start accepted at E6.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: loads a parallel word on a start/busy handshake, drives it MSB
// first onto a downstream shift register's serial input, then captures the
// register's parallel output and flags any difference from the sent word.
module shift_seq #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             ck,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             si,
  output logic             sen,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] word,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next-state and datapath updates for the shift / check / gap sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    sh_d    = sh_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    word_d  = word_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d    = din;
          exp_d   = din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // The downstream register has taken its last bit; q_in is the word.
        word_d = q_in;
        done_d = 1'b1;
        err_d  = err_q | (q_in != exp_q);
        gap_d  = '0;
        state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so they are stable all cycle.
  always_comb begin
    sen  = (state_q == ST_SHIFT);
    si   = (state_q == ST_SHIFT) ? sh_q[WIDTH-1] : 1'b0;
    busy = (state_q != ST_IDLE);
    done = done_q;
    word = word_q;
    err  = err_q;
  end

  // State register with synchronous reset that overrides any pending start.
  always_ff @(posedge ck) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (res) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
